// File: rtl/line_mem_pkg.sv
// Shared definitions for the line memory responder: line width, default
// geometry/latency and the responder state encoding.
package line_mem_pkg;

  localparam int LINE_W         = 128;
  localparam int DEF_ADDR_W     = 28;
  localparam int DEF_DEPTH_LOG2 = 8;
  localparam int DEF_LATENCY    = 4;

  // Latency counter width; LATENCY is legal in 1..255.
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/line_mem_array.sv
// 1R1W synchronous line storage. All lines and the read register clear on
// reset. The read register holds its value until the next read strobe.
// A read and a write to the same index in one cycle return the old line.
module line_mem_array
  import line_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [LINE_W-1:0]     wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [LINE_W-1:0]     rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [LINE_W-1:0] mem_d [DEPTH];
  logic [LINE_W-1:0] rdata_q;
  logic [LINE_W-1:0] rdata_d;

  // Next contents: one line replaced on a write strobe.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Read register loads only on a read strobe, otherwise holds.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  // Storage and read register, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/line_mem_responder.sv
// Memory-side responder for the cache's 128-bit line interface.
//
// Handshake: mem_read / mem_write are levels held by the requester until it
// sees the one-cycle mem_ready pulse. A request first seen in IDLE at cycle t
// completes with mem_ready high at cycle t+LATENCY+1. Address and write data
// are sampled only on the final BUSY edge. Dropping the request during BUSY
// aborts without committing anything. A request still high during the RESP
// cycle is ignored and picked up in the following IDLE cycle.
//
// Optional build macro LINE_MEM_STATS_EN adds rd_cnt / wr_cnt completion
// counters and a sticky proto_err flag (read and write high together).
module line_mem_responder
  import line_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic [1:0]        dbg_state
`ifdef LINE_MEM_STATS_EN
  ,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt,
  output logic              proto_err
`endif
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_wr_q, op_wr_d;
  logic               ready_q, ready_d;
  logic               arr_we;
  logic               arr_re;
  logic               complete;
  logic               req_held;
  logic [DEPTH_LOG2-1:0] line_idx;

  // Upper address bits alias onto the same lines.
  assign line_idx = mem_addr[DEPTH_LOG2-1:0];

  logic unused_addr_hi;
  assign unused_addr_hi = ^mem_addr[ADDR_W-1:DEPTH_LOG2];

  // The latched operation's own request line keeps the access alive.
  assign req_held = op_wr_q ? mem_write : mem_read;

  // Responder FSM: next state, latency counter, commit strobes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_wr_d  = op_wr_q;
    ready_d  = 1'b0;
    arr_we   = 1'b0;
    arr_re   = 1'b0;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_write || mem_read) begin
          op_wr_d = mem_write;  // write wins when both are high
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!req_held) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d  = ST_RESP;
          ready_d  = 1'b1;
          complete = 1'b1;
          arr_we   = op_wr_q;
          arr_re   = !op_wr_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, counter, latched op and ready pulse registers.
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      ready_q <= ready_d;
    end
  end

  line_mem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .rst_n (proc_reset_n),
    .we    (arr_we),
    .waddr (line_idx),
    .wdata (mem_wdata),
    .re    (arr_re),
    .raddr (line_idx),
    .rdata (mem_rdata)
  );

  assign mem_ready = ready_q;
  assign dbg_state = state_q;

`ifdef LINE_MEM_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic        proto_err_q, proto_err_d;

  // Completion counters (wrap naturally) and sticky protocol error.
  always_comb begin
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    proto_err_d = proto_err_q | (mem_read & mem_write);
    if (complete && op_wr_q) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
    if (complete && !op_wr_q) begin
      rd_cnt_d = rd_cnt_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;
  assign proto_err = proto_err_q;
`endif

endmodule
